// File: rtl/tpx3_rx_merge_if.sv
// Register bus and merged readout stream of tpx3_rx_merge.
// The master drives address/strobes and pops words; the slave is the merger.
interface tpx3_rx_merge_if #(
    parameter int unsigned ABUSWIDTH = 32
) ();
    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0]           BUS_DATA_IN;
    logic [7:0]           BUS_DATA_OUT;
    logic                 BUS_WR;
    logic                 BUS_RD;
    logic                 FIFO_READ;
    logic                 FIFO_EMPTY;
    logic [31:0]          FIFO_DATA;

    modport master (
        output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, FIFO_READ,
        input  BUS_DATA_OUT, FIFO_EMPTY, FIFO_DATA
    );

    modport slave (
        input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, FIFO_READ,
        output BUS_DATA_OUT, FIFO_EMPTY, FIFO_DATA
    );
endinterface

// File: rtl/tpx3_rx_merge.sv
// N-lane Timepix3 receiver merger: enable-masked round-robin over FWFT lane FIFOs
// into one 32-bit tagged stream, plus per-lane enable/counter register bank.
module tpx3_rx_merge #(
    parameter int unsigned CHANNELS        = 4,
    parameter logic [6:0]  DATA_IDENTIFIER = 7'h00,
    parameter int unsigned ABUSWIDTH       = 32
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST,
    input  logic [CHANNELS-1:0]     CH_EMPTY,
    input  logic [25*CHANNELS-1:0]  CH_DATA,
    output logic [CHANNELS-1:0]     CH_READ,
    input  logic [CHANNELS-1:0]     CH_DEC_ERR,
    output logic [CHANNELS-1:0]     RX_ENABLE,
    tpx3_rx_merge_if.slave          bus
);

    localparam logic [7:0]           VERSION      = 8'd2;
    localparam logic [ABUSWIDTH-1:0] ADDR_VERSION = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] ADDR_CHANS   = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] ADDR_MASK    = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] ADDR_SEL     = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] ADDR_CNT_LO  = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] ADDR_CNT_HI  = ABUSWIDTH'(5);
    localparam logic [ABUSWIDTH-1:0] ADDR_ERR     = ABUSWIDTH'(6);
    localparam logic [ABUSWIDTH-1:0] ADDR_STATUS  = ABUSWIDTH'(7);

    logic                r_out_valid;
    logic [31:0]         r_out_word;
    logic [2:0]          r_last;
    logic [CHANNELS-1:0] r_mask;
    logic [2:0]          r_sel;
    logic [7:0]          r_hi;
    logic [7:0]          r_rd_data;
    logic [15:0]         r_word_cnt [CHANNELS];
    logic [7:0]          r_err_cnt  [CHANNELS];

    logic                w_rst;
    logic                w_clr;
    logic                w_slot_free;
    logic [CHANNELS-1:0] w_cand;
    logic                w_any;
    logic                w_hit_hi;
    logic [2:0]          w_g_lo;
    logic [2:0]          w_g_hi;
    logic [2:0]          w_grant;
    logic                w_take;
    logic [CHANNELS-1:0] w_ch_read;
    logic [24:0]         w_gdata;
    logic [15:0]         w_sel_word;
    logic [7:0]          w_sel_err;
    logic [7:0]          w_rd_data;

    assign w_rst       = BUS_RST | (bus.BUS_WR & (bus.BUS_ADD == ADDR_VERSION));
    assign w_clr       = bus.BUS_WR & (bus.BUS_ADD == ADDR_CNT_LO);
    assign w_slot_free = !r_out_valid | bus.FIFO_READ;
    assign w_cand      = ~CH_EMPTY & r_mask;

    // Round robin: lowest candidate above last_grant, else wrap to lowest candidate.
    always_comb begin
        w_any    = 1'b0;
        w_hit_hi = 1'b0;
        w_g_lo   = '0;
        w_g_hi   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_cand[k] && !w_any) begin
                w_any  = 1'b1;
                w_g_lo = 3'(k);
            end
            if (w_cand[k] && !w_hit_hi && (3'(k) > r_last)) begin
                w_hit_hi = 1'b1;
                w_g_hi   = 3'(k);
            end
        end
        w_grant = w_hit_hi ? w_g_hi : w_g_lo;
        w_take  = w_slot_free & w_any & !w_rst;
    end

    always_comb begin
        w_ch_read = '0;
        w_gdata   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_ch_read[k] = w_take && (w_grant == 3'(k));
            if (w_grant == 3'(k))
                w_gdata = CH_DATA[25*k +: 25];
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (w_rst) begin
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_last      <= 3'(CHANNELS - 1);
        end else if (w_slot_free) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_word  <= {DATA_IDENTIFIER[6:3], w_grant, w_gdata};
                r_last      <= w_grant;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // A clear of the selected lane takes priority over a same-cycle increment.
    always_ff @(posedge BUS_CLK) begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_rst || (w_clr && (r_sel == 3'(k)))) begin
                r_word_cnt[k] <= '0;
                r_err_cnt[k]  <= '0;
            end else begin
                if (w_ch_read[k] && (r_word_cnt[k] != '1))
                    r_word_cnt[k] <= r_word_cnt[k] + 16'd1;
                if (CH_DEC_ERR[k] && (r_err_cnt[k] != '1))
                    r_err_cnt[k] <= r_err_cnt[k] + 8'd1;
            end
        end
    end

    always_comb begin
        w_sel_word = '0;
        w_sel_err  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (r_sel == 3'(k)) begin
                w_sel_word = r_word_cnt[k];
                w_sel_err  = r_err_cnt[k];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (bus.BUS_ADD == ADDR_VERSION)
            w_rd_data = VERSION;
        else if (bus.BUS_ADD == ADDR_CHANS)
            w_rd_data = 8'(CHANNELS);
        else if (bus.BUS_ADD == ADDR_MASK)
            w_rd_data = 8'(r_mask);
        else if (bus.BUS_ADD == ADDR_SEL)
            w_rd_data = {5'b0, r_sel};
        else if (bus.BUS_ADD == ADDR_CNT_LO)
            w_rd_data = w_sel_word[7:0];
        else if (bus.BUS_ADD == ADDR_CNT_HI)
            w_rd_data = r_hi;
        else if (bus.BUS_ADD == ADDR_ERR)
            w_rd_data = w_sel_err;
        else if (bus.BUS_ADD == ADDR_STATUS)
            w_rd_data = {6'b0, |w_cand, r_out_valid};
    end

    always_ff @(posedge BUS_CLK) begin
        if (w_rst) begin
            r_mask    <= '0;
            r_sel     <= '0;
            r_hi      <= '0;
            r_rd_data <= '0;
        end else begin
            if (bus.BUS_WR && (bus.BUS_ADD == ADDR_MASK))
                r_mask <= bus.BUS_DATA_IN[CHANNELS-1:0];
            if (bus.BUS_WR && (bus.BUS_ADD == ADDR_SEL))
                r_sel <= bus.BUS_DATA_IN[2:0];
            if (bus.BUS_RD) begin
                r_rd_data <= w_rd_data;
                if (bus.BUS_ADD == ADDR_CNT_LO)
                    r_hi <= w_sel_word[15:8];
            end
        end
    end

    assign CH_READ          = w_ch_read;
    assign RX_ENABLE        = r_mask;
    assign bus.FIFO_EMPTY   = !r_out_valid;
    assign bus.FIFO_DATA    = r_out_word;
    assign bus.BUS_DATA_OUT = r_rd_data;

endmodule
